// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants (used by uart_tx and the future uart_rx)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
  localparam int unsigned UART_DATA_WIDTH      = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter, pulses o_bit_end on the last cycle of each bit
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_bit_end
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_bit_end = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_bit_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1/8N2 UART transmitter draining an FWFT FIFO; parity bit when UART_TX_PARITY_EN is defined
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int unsigned STOP_BITS    = 1,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_tx_en,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_rd_en,
  output logic                  o_tx,
  output logic                  o_busy
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  tx_state_t             r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_tx;
  logic                  r_rd;
  logic                  r_busy;

  tx_state_t             w_state_nx;
  logic [DATA_WIDTH-1:0] w_shift_nx;
  logic [IDX_W-1:0]      w_idx_nx;
  logic                  w_tx_nx;
  logic                  w_bit_end;
  logic                  w_stop_last;
  logic                  w_pop;
  logic                  w_clear;

`ifdef UART_TX_PARITY_EN
  logic r_par;
`else
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = PARITY_ODD;
`endif

  // r_idx counts data bits in DATA and stop bits in STOP
  assign w_stop_last = (r_state == STOP) && w_bit_end && (r_idx == IDX_W'(STOP_BITS - 1));
  assign w_pop       = i_tx_en && !i_fifo_empty && ((r_state == IDLE) || w_stop_last);
  assign w_clear     = (r_state == IDLE) || w_pop;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_clear),
    .o_bit_end(w_bit_end)
  );

  always_comb begin
    w_state_nx = r_state;
    w_shift_nx = r_shift;
    w_idx_nx   = r_idx;
    w_tx_nx    = 1'b1;

    case (r_state)
      IDLE: ;
      START: begin
        if (w_bit_end) begin
          w_state_nx = DATA;
          w_idx_nx   = '0;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift_nx = r_shift >> 1;
          if (r_idx == IDX_W'(DATA_WIDTH - 1)) begin
            w_idx_nx = '0;
`ifdef UART_TX_PARITY_EN
            w_state_nx = PARITY;
`else
            w_state_nx = STOP;
`endif
          end else begin
            w_idx_nx = r_idx + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_state_nx = STOP;
          w_idx_nx   = '0;
        end
      end
`endif
      STOP: begin
        if (w_stop_last) begin
          w_state_nx = IDLE;
        end else if (w_bit_end) begin
          w_idx_nx = r_idx + 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase

    // A pop from IDLE or the final stop cycle starts the next frame with no gap
    if (w_pop) begin
      w_state_nx = START;
      w_shift_nx = i_fifo_data;
      w_idx_nx   = '0;
    end

    case (w_state_nx)
      START:   w_tx_nx = 1'b0;
      DATA:    w_tx_nx = w_shift_nx[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_nx = r_par;
`endif
      default: w_tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_tx    <= 1'b1;
      r_rd    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_shift <= w_shift_nx;
      r_idx   <= w_idx_nx;
      r_tx    <= w_tx_nx;
      r_rd    <= w_pop;
      r_busy  <= (w_state_nx != IDLE);
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is taken from the whole byte at pop time, before it is shifted out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if (w_pop) begin
      r_par <= (^i_fifo_data) ^ PARITY_ODD;
    end
  end
`endif

  assign o_fifo_rd_en = r_rd;
  assign o_tx         = r_tx;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx with an FWFT FIFO model and frame-level line model
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int C = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PAR   = 1;
  localparam int FRAME = 176;
`else
  localparam int PAR   = 0;
  localparam int FRAME = 160;
`endif
  localparam int MLEN = (1 + 8 + PAR + 1) * C;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_tx_en;
  logic       i_fifo_empty;
  logic [7:0] i_fifo_data;
  logic       o_fifo_rd_en;
  logic       o_tx;
  logic       o_busy;

  always #5 clk = ~clk;

  uart_tx #(
    .CLKS_PER_BIT(C),
    .DATA_WIDTH  (8),
    .STOP_BITS   (1),
    .PARITY_ODD  (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_tx_en     (i_tx_en),
    .i_fifo_empty(i_fifo_empty),
    .i_fifo_data (i_fifo_data),
    .o_fifo_rd_en(o_fifo_rd_en),
    .o_tx        (o_tx),
    .o_busy      (o_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // FWFT FIFO: pops on the edge where rd_en is high
  logic [7:0] fq[$];
  bit         fifo_rd_s;
  always @(posedge clk) begin
    fifo_rd_s = o_fifo_rd_en;
    #1;
    if (fifo_rd_s) begin
      if (fq.size() == 0) chk("fifo_underflow", 32'd1, 32'd0);
      else void'(fq.pop_front());
    end
    i_fifo_empty = (fq.size() == 0);
    i_fifo_data  = (fq.size() == 0) ? 8'hEE : fq[0];
  end

  // Frame-level model: a frame is MLEN cycles, bit k spans offsets k*C..k*C+C-1
  int         cyc = 0;
  bit         m_valid = 0, m_active = 0, m_rd = 0, m_last, m_pop;
  int         m_off = 0;
  logic [7:0] m_byte = 8'h00;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_valid  = 1;
      m_active = 0;
      m_rd     = 0;
      m_off    = 0;
    end else if (m_valid) begin
      m_last = m_active && (m_off == MLEN - 1);
      m_pop  = i_tx_en && !i_fifo_empty && (!m_active || m_last);
      m_rd   = m_pop;
      if (m_pop) begin
        m_active = 1;
        m_off    = 0;
        m_byte   = i_fifo_data;
      end else if (m_last) begin
        m_active = 0;
      end else if (m_active) begin
        m_off++;
      end
    end
  end

  function automatic logic exp_tx();
    int         b;
    logic [7:0] t;
    if (!m_active) return 1'b1;
    b = m_off / C;
    if (b == 0) return 1'b0;
    if (b <= 8) begin
      t = m_byte >> (b - 1);
      return t[0];
    end
    if (PAR == 1 && b == 9) return ^m_byte;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      chk("tx", 32'(o_tx), 32'(exp_tx()));
      chk("busy", 32'(o_busy), 32'(m_active));
      chk("rd_en", 32'(o_fifo_rd_en), 32'(m_rd));
    end
  end

  // Line decoder and activity counters, sampling mid-bit
  int         rd_cnt = 0, busy_cnt = 0, busy_run = 0, busy_max = 0;
  int         rd_cycles[$];
  logic [7:0] dec_q[$];
  logic       dec_par[$];
  bit         dec_active = 0;
  int         dec_cnt = 0;
  int         dec_b;
  logic [7:0] dec_sh;

  always @(negedge clk) begin
    if (o_busy === 1'b1) begin
      busy_cnt++;
      busy_run++;
      if (busy_run > busy_max) busy_max = busy_run;
    end else begin
      busy_run = 0;
    end
    if (o_fifo_rd_en === 1'b1) begin
      rd_cnt++;
      rd_cycles.push_back(cyc);
    end
    if (rst_n !== 1'b1) begin
      dec_active = 0;
    end else if (!dec_active) begin
      if (o_tx === 1'b0) begin
        dec_active = 1;
        dec_cnt    = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt % C == C / 2) begin
        dec_b = dec_cnt / C;
        if (dec_b == 0) chk("start_bit", 32'(o_tx), 32'd0);
        else if (dec_b <= 8) dec_sh = {o_tx, dec_sh[7:1]};
        else if (PAR == 1 && dec_b == 9) dec_par.push_back(o_tx);
        else begin
          chk("stop_bit", 32'(o_tx), 32'd1);
          dec_q.push_back(dec_sh);
          dec_active = 0;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_counts();
    rd_cnt   = 0;
    busy_cnt = 0;
    busy_max = 0;
    rd_cycles.delete();
    dec_q.delete();
    dec_par.delete();
  endtask

  task automatic wait_dec(input int n, input int budget, input string name);
    int k = 0;
    while (dec_q.size() < n && k < budget) begin
      step(1);
      k++;
    end
    chk(name, 32'(dec_q.size()), 32'(n));
  endtask

  task automatic wait_rd(input int n, input int budget, input string name);
    int k = 0;
    while (rd_cnt < n && k < budget) begin
      step(1);
      k++;
    end
    chk(name, 32'(rd_cnt), 32'(n));
  endtask

  initial begin
    rst_n        = 1'b0;
    i_tx_en      = 1'b0;
    i_fifo_empty = 1'b1;
    i_fifo_data  = 8'h00;
    step(3);
    chk("reset_tx", 32'(o_tx), 32'd1);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_rd", 32'(o_fifo_rd_en), 32'd0);
    rst_n = 1'b1;

    // Empty FIFO with transmit enabled
    i_tx_en = 1'b1;
    clear_counts();
    step(100);
    chk("t1_rd_cnt", 32'(rd_cnt), 32'd0);
    chk("t1_busy_cnt", 32'(busy_cnt), 32'd0);
    chk("t1_tx_idle", 32'(o_tx), 32'd1);

    // Single byte
    clear_counts();
    fq.push_back(8'hA5);
    wait_dec(1, 3 * FRAME, "t2_decoded_count");
    step(20);
    chk("t2_byte", 32'(dec_q[0]), 32'hA5);
    chk("t2_rd_cnt", 32'(rd_cnt), 32'd1);
    chk("t2_busy_cnt", 32'(busy_cnt), 32'(FRAME));
    chk("t2_busy_run", 32'(busy_max), 32'(FRAME));

    // Back-to-back frames
    clear_counts();
    fq.push_back(8'h11);
    fq.push_back(8'h22);
    fq.push_back(8'h33);
    wait_dec(3, 5 * FRAME, "t3_decoded_count");
    step(20);
    chk("t3_byte0", 32'(dec_q[0]), 32'h11);
    chk("t3_byte1", 32'(dec_q[1]), 32'h22);
    chk("t3_byte2", 32'(dec_q[2]), 32'h33);
    chk("t3_rd_cnt", 32'(rd_cnt), 32'd3);
    chk("t3_gap01", 32'(rd_cycles[1] - rd_cycles[0]), 32'(FRAME));
    chk("t3_gap12", 32'(rd_cycles[2] - rd_cycles[1]), 32'(FRAME));
    chk("t3_busy_run", 32'(busy_max), 32'(3 * FRAME));

    // Enable dropped mid-frame
    i_tx_en = 1'b0;
    clear_counts();
    fq.push_back(8'h55);
    fq.push_back(8'h66);
    step(10);
    chk("t4_gated_rd", 32'(rd_cnt), 32'd0);
    i_tx_en = 1'b1;
    wait_rd(1, 20, "t4_first_pop");
    step(39);
    i_tx_en = 1'b0;
    step(2 * FRAME);
    chk("t4_decoded_count", 32'(dec_q.size()), 32'd1);
    chk("t4_byte0", 32'(dec_q[0]), 32'h55);
    chk("t4_rd_cnt", 32'(rd_cnt), 32'd1);
    chk("t4_fifo_left", 32'(fq.size()), 32'd1);
    chk("t4_idle_busy", 32'(o_busy), 32'd0);
    i_tx_en = 1'b1;
    wait_dec(2, 2 * FRAME, "t4_decoded_after");
    step(20);
    chk("t4_byte1", 32'(dec_q[1]), 32'h66);
    chk("t4_rd_cnt2", 32'(rd_cnt), 32'd2);

    // Reset mid-frame
    clear_counts();
    fq.push_back(8'h3C);
    fq.push_back(8'h4B);
    wait_rd(1, 20, "t5_first_pop");
    step(49);
    rst_n = 1'b0;
    step(1);
    chk("t5_tx_after_reset", 32'(o_tx), 32'd1);
    chk("t5_busy_after_reset", 32'(o_busy), 32'd0);
    chk("t5_rd_in_reset", 32'(o_fifo_rd_en), 32'd0);
    step(2);
    chk("t5_rd_cnt", 32'(rd_cnt), 32'd1);
    chk("t5_fifo_left", 32'(fq.size()), 32'd1);
    chk("t5_fifo_head", 32'(fq[0]), 32'h4B);
    chk("t5_no_decode", 32'(dec_q.size()), 32'd0);
    rst_n = 1'b1;
    wait_dec(1, 2 * FRAME, "t5_decoded_after");
    step(20);
    chk("t5_byte", 32'(dec_q[0]), 32'h4B);
    chk("t5_rd_cnt2", 32'(rd_cnt), 32'd2);

`ifdef UART_TX_PARITY_EN
    // Even parity
    clear_counts();
    fq.push_back(8'h07);
    wait_dec(1, 3 * FRAME, "t6_decoded_07");
    step(20);
    chk("t6_byte_07", 32'(dec_q[0]), 32'h07);
    chk("t6_par_07", 32'(dec_par[0]), 32'd1);
    chk("t6_busy_07", 32'(busy_cnt), 32'd176);
    clear_counts();
    fq.push_back(8'h03);
    wait_dec(1, 3 * FRAME, "t6_decoded_03");
    step(20);
    chk("t6_byte_03", 32'(dec_q[0]), 32'h03);
    chk("t6_par_03", 32'(dec_par[0]), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
